// File: rtl/bcd_lap_timer.sv
// rtl/bcd_lap_timer.sv - BCD HH:MM:SS.hh stopwatch with lap capture and live/hold/recall view
module bcd_lap_timer #(
    parameter int LAP_DEPTH  = 4,
    parameter int HOLD_TICKS = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        clear,
    input  logic        lap,
    input  logic        recall,
    output logic [31:0] data,
    output logic [1:0]  view_mode,
    output logic [2:0]  lap_count,
    output logic [2:0]  lap_index,
    output logic        overflow
);

    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {LIVE = 2'b00, HOLD = 2'b01, RECALL = 2'b10} viewState_t;

    viewState_t     state, nState;
    logic [31:0]    liveTime, nLive, liveInc, nData, holdVal, recallVal;
    logic [31:0]    slots [LAP_DEPTH];
    logic [HW-1:0]  holdCnt, nHold;
    logic [2:0]     holdIdx, nHoldIdx, nCount, nIdx;
    logic           nOvf, wrap, doWrite;

    // Ripple carry through the digits; s10 and m10 roll over at 5, the rest at 9.
    function automatic logic [32:0] bcdInc(input logic [31:0] t);
        logic [31:0] r;
        logic        carry;
        logic [3:0]  lim;
        logic [3:0]  d;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            d   = t[i*4 +: 4];
            if (carry) begin
                if (d == lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return {carry, r};
    endfunction

    always_comb begin
        {wrap, liveInc} = bcdInc(liveTime);
        nLive    = liveTime;
        nOvf     = overflow;
        nState   = state;
        nCount   = lap_count;
        nIdx     = lap_index;
        nHold    = holdCnt;
        nHoldIdx = holdIdx;
        doWrite  = 1'b0;
        if (clear) begin
            nLive    = '0;
            nOvf     = 1'b0;
            nState   = LIVE;
            nCount   = '0;
            nIdx     = '0;
            nHold    = '0;
            nHoldIdx = '0;
        end else begin
            if (tick) begin
                nLive = liveInc;
                if (wrap) nOvf = 1'b1;
            end
            if (lap) begin
                if (lap_count < 3'(LAP_DEPTH)) begin
                    doWrite  = 1'b1;
                    nCount   = lap_count + 3'd1;
                    nHoldIdx = lap_count;
                end else begin
                    nHoldIdx = 3'(LAP_DEPTH - 1);
                end
                nState = HOLD;
                nHold  = HW'(HOLD_TICKS);
                nIdx   = '0;
            end else if (recall) begin
                case (state)
                    LIVE: if (lap_count != 3'd0) begin
                        nState = RECALL;
                        nIdx   = '0;
                    end
                    HOLD: begin
                        nState = RECALL;
                        nIdx   = '0;
                        nHold  = '0;
                    end
                    RECALL: if (lap_index < lap_count - 3'd1) begin
                        nIdx = lap_index + 3'd1;
                    end else begin
                        nState = LIVE;
                        nIdx   = '0;
                    end
                    default: nState = LIVE;
                endcase
            end else if (state == HOLD && tick) begin
                if (holdCnt <= HW'(1)) begin
                    nState = LIVE;
                    nHold  = '0;
                end else begin
                    nHold = holdCnt - HW'(1);
                end
            end
        end

        holdVal   = '0;
        recallVal = '0;
        for (int i = 0; i < LAP_DEPTH; i++) begin
            if (nHoldIdx == 3'(i)) holdVal = slots[i];
            if (nIdx == 3'(i))     recallVal = slots[i];
        end

        // A slot being written this cycle is not visible in slots[] yet, so show the capture source.
        case (nState)
            HOLD:    nData = doWrite ? liveTime : holdVal;
            RECALL:  nData = recallVal;
            default: nData = nLive;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LIVE;
            liveTime  <= '0;
            data      <= '0;
            lap_count <= '0;
            lap_index <= '0;
            overflow  <= 1'b0;
            holdCnt   <= '0;
            holdIdx   <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) slots[i] <= '0;
        end else begin
            state     <= nState;
            liveTime  <= nLive;
            data      <= nData;
            lap_count <= nCount;
            lap_index <= nIdx;
            overflow  <= nOvf;
            holdCnt   <= nHold;
            holdIdx   <= nHoldIdx;
            for (int i = 0; i < LAP_DEPTH; i++) begin
                if (doWrite && lap_count == 3'(i)) slots[i] <= liveTime;
            end
        end
    end

    assign view_mode = state;

endmodule

// File: tb/tb_bcd_lap_timer.sv
// tb/tb_bcd_lap_timer.sv - directed self-checking bench for bcd_lap_timer
module tb_bcd_lap_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic        recall = 1'b0;
    logic [31:0] data;
    logic [1:0]  view_mode;
    logic [2:0]  lap_count;
    logic [2:0]  lap_index;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int bcdBad = 0;
    logic [31:0] slotExp [4];

    bcd_lap_timer #(.LAP_DEPTH(4), .HOLD_TICKS(200)) dut (
        .clk(clk), .reset(reset), .tick(tick), .clear(clear), .lap(lap), .recall(recall),
        .data(data), .view_mode(view_mode), .lap_count(lap_count), .lap_index(lap_index),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit validBcd(input logic [31:0] d);
        for (int i = 0; i < 8; i++) if (d[i*4 +: 4] > 4'd9) return 1'b0;
        if (d[15:12] > 4'd5 || d[23:20] > 4'd5) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step(input logic t, input logic c, input logic l, input logic r);
        tick = t; clear = c; lap = l; recall = r;
        @(negedge clk);
        tick = 1'b0; clear = 1'b0; lap = 1'b0; recall = 1'b0;
    endtask

    task automatic runTicks(input int n);
        tick = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (!validBcd(data)) bcdBad++;
        end
        tick = 1'b0;
    endtask

    initial begin
        slotExp[0] = 32'h05; slotExp[1] = 32'h10; slotExp[2] = 32'h15; slotExp[3] = 32'h20;

        repeat (2) @(negedge clk);
        chk("reset_data", data, 32'h0);
        chk("reset_view", 32'(view_mode), 32'h0);
        chk("reset_count", 32'(lap_count), 32'h0);
        chk("reset_index", 32'(lap_index), 32'h0);
        chk("reset_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;

        runTicks(100);
        chk("t100_data", data, 32'h00000100);
        chk("t100_view", 32'(view_mode), 32'h0);
        chk("t100_ovf", 32'(overflow), 32'h0);

        step(0, 1, 0, 0);
        runTicks(6099);
        chk("t6099_data", data, 32'h00010099);
        runTicks(1);
        chk("t6100_data", data, 32'h00010100);
        chk("bcd_valid", 32'(bcdBad), 32'h0);

        force dut.liveTime = 32'h99595999;
        @(negedge clk);
        release dut.liveTime;
        chk("preload_data", data, 32'h99595999);
        chk("preload_ovf", 32'(overflow), 32'h0);
        runTicks(1);
        chk("wrap_data", data, 32'h0);
        chk("wrap_ovf", 32'(overflow), 32'h1);
        runTicks(3);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        step(0, 1, 0, 0);
        chk("clear_ovf", 32'(overflow), 32'h0);
        chk("clear_data", data, 32'h0);

        runTicks(512);
        chk("pre_lap_data", data, 32'h00000512);
        step(1, 0, 1, 0);
        chk("lap_count1", 32'(lap_count), 32'h1);
        chk("lap_view_hold", 32'(view_mode), 32'h1);
        chk("lap_data", data, 32'h00000512);
        runTicks(199);
        chk("hold199_view", 32'(view_mode), 32'h1);
        chk("hold199_data", data, 32'h00000512);
        runTicks(1);
        chk("hold_end_view", 32'(view_mode), 32'h0);
        chk("hold_end_data", data, 32'h00000713);

        step(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            runTicks(5);
            step(0, 0, 1, 0);
        end
        chk("full_count", 32'(lap_count), 32'h4);
        chk("full_view", 32'(view_mode), 32'h1);
        chk("full_data", data, 32'h20);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1);
            chk($sformatf("recall%0d_view", i), 32'(view_mode), 32'h2);
            chk($sformatf("recall%0d_index", i), 32'(lap_index), 32'(i));
            chk($sformatf("recall%0d_data", i), data, slotExp[i]);
        end
        step(0, 0, 0, 1);
        chk("recall_exit_view", 32'(view_mode), 32'h0);
        chk("recall_exit_index", 32'(lap_index), 32'h0);
        chk("recall_exit_data", data, 32'h25);

        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("empty_recall_view", 32'(view_mode), 32'h0);
        chk("empty_recall_index", 32'(lap_index), 32'h0);
        chk("empty_recall_count", 32'(lap_count), 32'h0);
        runTicks(3);
        step(0, 0, 1, 1);
        chk("lap_wins_view", 32'(view_mode), 32'h1);
        chk("lap_wins_count", 32'(lap_count), 32'h1);
        chk("lap_wins_data", data, 32'h03);

        step(0, 0, 0, 1);
        chk("pre_reset_view", 32'(view_mode), 32'h2);
        chk("pre_reset_data", data, 32'h03);
        #2 reset = 1'b1;
        #1;
        chk("async_data", data, 32'h0);
        chk("async_view", 32'(view_mode), 32'h0);
        chk("async_count", 32'(lap_count), 32'h0);
        chk("async_index", 32'(lap_index), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
